// File: rtl/tmds_encoder_pipe.sv
// Per-channel TMDS encoder: 8b/10b video with running disparity, control tokens,
// TERC4 data-island symbols and guard bands, in a two-stage pipe gated by ce.
module tmds_encoder_pipe #(
    parameter logic [9:0] GUARD_WORD   = 10'b1011001100,
    parameter bit         ENABLE_TERC4 = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [1:0]        mode,
    input  logic [7:0]        D,
    input  logic [1:0]        c,
    input  logic [3:0]        terc,
    output logic [9:0]        q_out,
    output logic signed [4:0] cnt_dbg
);

    typedef enum logic [1:0] {
        MODE_VIDEO = 2'd0,
        MODE_CTRL  = 2'd1,
        MODE_TERC4 = 2'd2,
        MODE_GUARD = 2'd3
    } mode_e;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
        return s;
    endfunction

    // XOR/XNOR chain chosen to minimise transitions; bit 8 flags XOR (1) vs XNOR (0).
    function automatic logic [8:0] minimise(input logic [7:0] d);
        logic [3:0] n1;
        logic       inv;
        logic [8:0] qm;
        n1    = popcnt8(d);
        inv   = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        qm    = '0;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i] ^ inv;
        qm[8] = ~inv;
        return qm;
    endfunction

    function automatic logic [9:0] ctrl_word(input logic [1:0] cc);
        logic [9:0] w;
        case (cc)
            2'b00:   w = 10'b1101010100;
            2'b01:   w = 10'b0010101011;
            2'b10:   w = 10'b0101010100;
            default: w = 10'b1010101011;
        endcase
        return w;
    endfunction

    function automatic logic [9:0] terc4_word(input logic [3:0] t);
        logic [9:0] w;
        case (t)
            4'h0:    w = 10'b1010011100;
            4'h1:    w = 10'b1001100011;
            4'h2:    w = 10'b1011100100;
            4'h3:    w = 10'b1011100010;
            4'h4:    w = 10'b0101110001;
            4'h5:    w = 10'b0100011110;
            4'h6:    w = 10'b0110001110;
            4'h7:    w = 10'b0100111100;
            4'h8:    w = 10'b1011001100;
            4'h9:    w = 10'b0100111001;
            4'hA:    w = 10'b0110011100;
            4'hB:    w = 10'b1011000111;
            4'hC:    w = 10'b1010001110;
            4'hD:    w = 10'b1001110001;
            4'hE:    w = 10'b0101100011;
            default: w = 10'b1011000011;
        endcase
        return w;
    endfunction

    // ---------------- stage 1: transition minimisation ----------------
    logic [8:0] s1_qm_q,   s1_qm_d;
    mode_e      s1_mode_q, s1_mode_d;
    logic [1:0] s1_c_q,    s1_c_d;
    logic [3:0] s1_terc_q, s1_terc_d;

    always_comb begin
        s1_qm_d   = s1_qm_q;
        s1_mode_d = s1_mode_q;
        s1_c_d    = s1_c_q;
        s1_terc_d = s1_terc_q;
        if (ce) begin
            s1_qm_d   = minimise(D);
            s1_mode_d = mode_e'(mode);
            s1_c_d    = c;
            s1_terc_d = terc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_qm_q   <= '0;
            s1_mode_q <= MODE_CTRL;
            s1_c_q    <= 2'b00;
            s1_terc_q <= '0;
        end else begin
            s1_qm_q   <= s1_qm_d;
            s1_mode_q <= s1_mode_d;
            s1_c_q    <= s1_c_d;
            s1_terc_q <= s1_terc_d;
        end
    end

    // ---------------- stage 2: DC balance and symbol select ----------------
    logic [9:0] q_out_q, q_out_d;
    logic [4:0] cnt_q,   cnt_d;
    logic [3:0] n1q;
    logic [4:0] bal;     // n1q - n0q, modulo 32
    logic       qm8;
    logic       cnt_pos, cnt_neg;

    always_comb begin
        n1q     = popcnt8(s1_qm_q[7:0]);
        bal     = {n1q, 1'b0} - 5'd8;
        qm8     = s1_qm_q[8];
        cnt_neg = cnt_q[4];
        cnt_pos = !cnt_q[4] && (cnt_q != 5'd0);
        q_out_d = q_out_q;
        cnt_d   = cnt_q;
        if (ce) begin
            case (s1_mode_q)
                MODE_VIDEO: begin
                    if ((cnt_q == 5'd0) || (n1q == 4'd4)) begin
                        q_out_d = {~qm8, qm8, qm8 ? s1_qm_q[7:0] : ~s1_qm_q[7:0]};
                        cnt_d   = cnt_q + (qm8 ? bal : (5'd0 - bal));
                    end else if ((cnt_pos && (n1q > 4'd4)) || (cnt_neg && (n1q < 4'd4))) begin
                        q_out_d = {1'b1, qm8, ~s1_qm_q[7:0]};
                        cnt_d   = cnt_q + {3'b000, qm8, 1'b0} - bal;
                    end else begin
                        q_out_d = {1'b0, qm8, s1_qm_q[7:0]};
                        cnt_d   = cnt_q + bal - {3'b000, ~qm8, 1'b0};
                    end
                end
                MODE_CTRL: begin
                    q_out_d = ctrl_word(s1_c_q);
                    cnt_d   = '0;
                end
                MODE_TERC4: begin
                    // Without data-island support the slot degrades to a control token.
                    q_out_d = ENABLE_TERC4 ? terc4_word(s1_terc_q) : ctrl_word(s1_c_q);
                    cnt_d   = '0;
                end
                default: begin
                    q_out_d = GUARD_WORD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_out_q <= CTRL_00;
            cnt_q   <= '0;
        end else begin
            q_out_q <= q_out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q_out   = q_out_q;
    assign cnt_dbg = cnt_q;

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// Randomised scoreboard bench for tmds_encoder_pipe against a behavioural TMDS model.
module tb_tmds_encoder_pipe;

    logic              clk = 1'b0;
    logic              rst, ce;
    logic [1:0]        mode, c;
    logic [7:0]        D;
    logic [3:0]        terc;
    logic [9:0]        q_out;
    logic signed [4:0] cnt_dbg;

    always #5 clk = ~clk;

    tmds_encoder_pipe dut (
        .clk(clk), .rst(rst), .ce(ce), .mode(mode), .D(D), .c(c), .terc(terc),
        .q_out(q_out), .cnt_dbg(cnt_dbg)
    );

    typedef struct {
        logic [9:0] q;
        int         cnt;
        logic [1:0] mode;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   mcnt   = 0;
    bit   issue  = 1'b0;
    bit   stall_en = 1'b0;

    localparam logic [9:0] CTRL0 = 10'b1101010100;
    localparam logic [9:0] GUARD = 10'b1011001100;
    logic [9:0] ctrl_tab [4]  = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    logic [9:0] terc_tab [16] = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                                  10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                                  10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000111,
                                  10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Reference: symbol sequence as a function of the inputs only, independent of ce timing.
    task automatic model(input logic [1:0] m, input logic [7:0] d, input logic [1:0] cc,
                         input logic [3:0] t, output logic [9:0] q);
        int       n1, ones, bal;
        bit       inv, xr;
        bit [7:0] qm;
        case (m)
            2'd0: begin
                n1  = $countones(d);
                inv = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
                qm[0] = d[0];
                for (int i = 1; i < 8; i++) qm[i] = inv ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
                xr   = !inv;
                ones = $countones(qm);
                bal  = ones - (8 - ones);
                if (mcnt == 0 || bal == 0) begin
                    q    = {~xr, xr, xr ? qm : ~qm};
                    mcnt = mcnt + (xr ? bal : -bal);
                end else if ((mcnt > 0 && bal > 0) || (mcnt < 0 && bal < 0)) begin
                    q    = {1'b1, xr, ~qm};
                    mcnt = mcnt + (xr ? 2 : 0) - bal;
                end else begin
                    q    = {1'b0, xr, qm};
                    mcnt = mcnt + bal - (xr ? 0 : 2);
                end
            end
            2'd1: begin q = ctrl_tab[cc]; mcnt = 0; end
            2'd2: begin q = terc_tab[t];  mcnt = 0; end
            default: begin q = GUARD; mcnt = 0; end
        endcase
    endtask

    task automatic send(input logic [1:0] m, input logic [7:0] d, input logic [1:0] cc, input logic [3:0] t);
        logic [9:0] q;
        exp_t       e;
        @(negedge clk);
        mode = m; D = d; c = cc; terc = t; issue = 1'b1; ce = 1'b1;
        model(m, d, cc, t, q);
        e.q = q; e.cnt = mcnt; e.mode = m; e.d = d;
        sb.push_back(e);
        if (stall_en) begin
            while ($urandom_range(0, 2) == 0) begin
                ce = 1'b0;
                @(negedge clk);
                mode = 2'($urandom); D = 8'($urandom); c = 2'($urandom); terc = 4'($urandom);
                @(negedge clk);
                mode = m; D = d; c = cc; terc = t;
            end
            ce = 1'b1;
        end
    endtask

    task automatic send_rand_video();
        send(2'd0, 8'($urandom), 2'($urandom), 4'($urandom));
    endtask

    // Monitor: tracks which ce=1 edges deliver scoreboarded symbols.
    initial begin
        logic [1:0] vld, rfill;
        logic       ce_s, rst_s, iss_s;
        logic [9:0] pq, dec, bits;
        int         pc, a;
        exp_t       e;
        vld = '0; rfill = '0; pq = '0; pc = 0;
        forever begin
            @(posedge clk);
            ce_s = ce; rst_s = rst; iss_s = issue;
            #1;
            if (rst_s) begin
                vld = '0; rfill = 2'b01;
                chk("rst_q", q_out, CTRL0);
                chk("rst_cnt", cnt_dbg, 0);
            end else if (ce_s) begin
                vld   = {vld[0], iss_s};
                rfill = {rfill[0], 1'b0};
                if (rfill[1]) begin
                    chk("fill_q", q_out, CTRL0);
                    chk("fill_cnt", cnt_dbg, 0);
                end
                if (vld[1]) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sb_underflow: output with no expected entry at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        a = cnt_dbg;
                        chk("q_out", q_out, e.q);
                        chk("cnt_dbg", a, e.cnt);
                        if (e.mode == 2'd0) begin
                            bits = q_out[9] ? {2'b00, ~q_out[7:0]} : {2'b00, q_out[7:0]};
                            dec  = '0;
                            dec[0] = bits[0];
                            for (int i = 1; i < 8; i++)
                                dec[i] = q_out[8] ? (bits[i] ^ bits[i-1]) : ~(bits[i] ^ bits[i-1]);
                            chk("decode", dec, {2'b00, e.d});
                            chk("cnt_range", int'(a >= -10 && a <= 10), 1);
                        end
                    end
                end
            end else begin
                a = cnt_dbg;
                chk("stall_q", q_out, pq);
                chk("stall_cnt", a, pc);
            end
            pq = q_out; pc = cnt_dbg;
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: stimulus did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int perm [256];
        int j, tmp;
        rst = 1'b1; ce = 1'b1; mode = 2'd1; c = 2'b00; D = '0; terc = '0; issue = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed disparity run, then reset while cnt=+2 with a symbol still in flight.
        send(2'd0, 8'h00, 2'b00, 4'h0);
        send(2'd0, 8'h00, 2'b00, 4'h0);
        @(negedge clk);
        issue = 1'b0; mode = 2'd0; D = 8'h55; ce = 1'b1;
        @(negedge clk);
        rst = 1'b1; ce = 1'b0;
        @(negedge clk);
        rst = 1'b0; ce = 1'b1; mode = 2'd1; c = 2'b00;
        mcnt = 0;
        sb.delete();

        send(2'd1, 8'h00, 2'b00, 4'h0);
        send(2'd0, 8'hFF, 2'b00, 4'h0);

        // Every non-video word, each followed by video that must restart from cnt=0.
        for (int k = 0; k < 4; k++) begin
            send_rand_video();
            send(2'd1, 8'($urandom), 2'(k), 4'($urandom));
            send_rand_video();
        end
        for (int k = 0; k < 16; k++) begin
            send_rand_video();
            send(2'd2, 8'($urandom), 2'($urandom), 4'(k));
            send_rand_video();
        end
        send_rand_video();
        send(2'd3, 8'($urandom), 2'($urandom), 4'($urandom));
        send_rand_video();

        // All 256 bytes in shuffled order, each after a random-length video prefix.
        for (int k = 0; k < 256; k++) perm[k] = k;
        for (int k = 255; k > 0; k--) begin
            j = $urandom_range(0, k);
            tmp = perm[k]; perm[k] = perm[j]; perm[j] = tmp;
        end
        for (int k = 0; k < 256; k++) begin
            repeat ($urandom_range(0, 3)) send_rand_video();
            send(2'd0, 8'(perm[k]), 2'($urandom), 4'($urandom));
        end

        // Mixed-mode traffic with pseudo-random ce stalls.
        stall_en = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) send(2'($urandom), 8'($urandom), 2'($urandom), 4'($urandom));
            else send_rand_video();
        end
        stall_en = 1'b0;

        repeat (4) begin
            @(negedge clk);
            issue = 1'b0; ce = 1'b1; mode = 2'd1; c = 2'b00;
        end
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
